dtrs_unit: RTL and testbench



---
 rtl/dtrs_unit.sv | 110 +++++++++++
 tb/tb_dtrs_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dtrs_unit.sv
// Division by repeated subtraction. Operands arrive back-to-back on data_in
// (dividend with start, divisor on the following cycle); the divisor is
// subtracted from the working remainder once per cycle until it no longer fits.
module dtrs_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [2:0] {StIdle, StLoadB, StCheck, StSub, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;       // working remainder
    logic [WIDTH-1:0] d_q, d_d;       // divisor
    logic [WIDTH-1:0] q_q, q_d;       // subtraction counter
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            r_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            d_q         <= d_d;
            q_q         <= q_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Next-state and datapath update; everything holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        d_d         = d_q;
        q_d         = q_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    r_d     = data_in;
                    q_d     = '0;
                    dbz_d   = 1'b0;
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                d_d     = data_in;
                state_d = StCheck;
            end
            StCheck: begin
                if (d_q == '0) begin
                    quotient_d  = '0;
                    remainder_d = r_q;
                    dbz_d       = 1'b1;
                    state_d     = StDone;
                end else begin
                    state_d = StSub;
                end
            end
            StSub: begin
                // d_q >= 1 here, so r_q - d_q cannot underflow and q_q cannot wrap.
                if (r_q >= d_q) begin
                    r_d = r_q - d_q;
                    q_d = q_q + 1'b1;
                end else begin
                    quotient_d  = q_q;
                    remainder_d = r_q;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status and results come straight from registers.
    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        div_by_zero = dbz_q;
        quotient    = quotient_q;
        remainder   = remainder_q;
    end

endmodule

// File: tb/tb_dtrs_unit.sv
// Bench for dtrs_unit: directed cases with literal expectations plus random
// operations, all checked every cycle against a transaction-level model.
module tb_dtrs_unit;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks   = 0;
    int failures = 0;

    dtrs_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction model: an operation accepted at edge 0 finishes at edge
    // (divisor==0 ? 2 : dividend/divisor + 3); results are plain / and %.
    bit           m_active;
    int           m_cnt;
    int           m_lat;
    logic [W-1:0] m_a, m_b;
    logic [W-1:0] m_q, m_r;
    logic         m_dbz;

    initial begin
        m_active = 0; m_cnt = 0; m_lat = 0; m_a = '0; m_b = '0;
        m_q = '0; m_r = '0; m_dbz = 0;
    end

    // Model advance, sampling inputs on the same edge as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_cnt = 0; m_q = '0; m_r = '0; m_dbz = 0;
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt == 1) begin
                m_b   = data_in;
                m_lat = (m_b == 0) ? 2 : int'(m_a / m_b) + 3;
            end
            if (m_cnt == m_lat) begin
                m_dbz = (m_b == 0);
                m_q   = (m_b == 0) ? '0 : m_a / m_b;
                m_r   = (m_b == 0) ? m_a : m_a % m_b;
            end
            if (m_cnt == m_lat + 1) m_active = 0;
        end else if (start) begin
            m_active = 1;
            m_cnt    = 0;
            m_lat    = 1 << 30;
            m_a      = data_in;
            m_dbz    = 0;
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, m_active});
        check("done", {31'd0, done}, {31'd0, (m_active && m_cnt == m_lat)});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
        check("quotient", {16'd0, quotient}, {16'd0, m_q});
        check("remainder", {16'd0, remainder}, {16'd0, m_r});
    end

    // One operation; optionally pokes start during SUB and in the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input bit edbz, input int elat, input bit poke);
        int lat;
        @(negedge clk);
        start   = 1'b1;
        data_in = a;
        @(negedge clk);
        start   = 1'b0;
        data_in = b;
        lat = -1;
        for (int n = 1; n <= 70000; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (poke && n == 6) begin
                start   = 1'b1;
                data_in = 16'h0003;
            end else begin
                start = 1'b0;
            end
        end
        check("latency", lat, elat);
        check("op_quotient", {16'd0, quotient}, {16'd0, eq});
        check("op_remainder", {16'd0, remainder}, {16'd0, er});
        check("op_div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("held_quotient", {16'd0, quotient}, {16'd0, eq});
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_quotient", {16'd0, quotient}, 32'd0);
        rst_n = 1'b1;

        run_op(16'd100, 16'd7, 16'd14, 16'd2, 0, 17, 0);
        run_op(16'd5, 16'd9, 16'd0, 16'd5, 0, 3, 0);
        run_op(16'd0, 16'd3, 16'd0, 16'd0, 0, 3, 0);
        run_op(16'd9, 16'd9, 16'd1, 16'd0, 0, 4, 0);
        run_op(16'd12, 16'd0, 16'd0, 16'd12, 1, 2, 0);
        run_op(16'd10, 16'd3, 16'd3, 16'd1, 0, 6, 0);
        run_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 0, 4, 0);

        // Reset in the middle of SUB abandons 100/7.
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd100;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd7;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd20, 16'd6, 16'd3, 16'd2, 0, 6, 0);

        // Ignored start pulses during SUB and DONE.
        run_op(16'd100, 16'd7, 16'd14, 16'd2, 0, 17, 1);

        // Random operations with small quotients, some divide-by-zero.
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            if (i % 3 == 0) a = W'($urandom_range(0, 600));
            b = W'($urandom_range(256, 65535));
            if (i % 5 == 0) b = W'($urandom_range(1, 40));
            if (i % 7 == 0) b = '0;
            if (b != 0 && (a / b) > 16'd2000) a = b * 16'd3 + 16'd1;
            if (b == 0)
                run_op(a, b, 16'd0, a, 1, 2, i % 4 == 1);
            else
                run_op(a, b, a / b, a % b, 0, int'(a / b) + 3, i % 4 == 1);
        end

        run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 0, 65538, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
